// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared state encoding and constants for the USB receive controller.
package usb_rx_pkg;

    // Receive controller states; the CHK and STORE states each last one cycle.
    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        SYNC_WAIT  = 4'd1,
        SYNC_CHK   = 4'd2,
        PID_WAIT   = 4'd3,
        PID_CHK    = 4'd4,
        DATA_WAIT  = 4'd5,
        DATA_STORE = 4'd6,
        EOP_HOLD   = 4'd7,
        ERR_WAIT   = 4'd8,
        ERR_EOP    = 4'd9,
        ERR_IDLE   = 4'd10
    } state_t;

    // Expected SYNC pattern as assembled by the shift register.
    localparam logic [7:0] SYNC_BYTE      = 8'h80;
    // Largest data payload accepted before the packet is flagged as an error.
    localparam logic [6:0] MAX_DATA_BYTES = 7'd64;

endpackage

// File: rtl/usb_rx_pid_check.sv
// usb_rx_pid_check: combinational PID validation.
// Build option: USB_RX_PID_CHECK_EN enables the upper-nibble complement check;
// without it every PID is accepted and the upper nibble is ignored.
module usb_rx_pid_check (
    input  logic [7:0] pid_byte,
    output logic       valid
);

`ifdef USB_RX_PID_CHECK_EN
    // The upper nibble of a PID byte carries the complement of the lower nibble.
    assign valid = (pid_byte[7:4] == ~pid_byte[3:0]);
`else
    // No check: any PID is taken as-is.
    assign valid = 1'b1;
`endif

endmodule

// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl: packet-level receive controller sitting behind the bit/byte
// assembler. Input strobes (d_edge, byte_received, eop qualified by
// shift_enable) are single-cycle events sampled on the clk rising edge; the
// controller has no back-pressure, so w_enable is a one-cycle write strobe with
// rcv_data as its payload and the FIFO must accept it in that cycle.
// state_dbg exposes the current FSM state for observation.
// Build option: USB_RX_PID_CHECK_EN (see usb_rx_pid_check).
module usb_rx_ctrl
    import usb_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       d_edge,
    input  logic       eop,
    input  logic       shift_enable,
    input  logic       byte_received,
    input  logic [7:0] rcv_data,
    output logic       receiving,
    output logic       w_enable,
    output logic       r_error,
    output logic [3:0] pid,
    output logic       pkt_done,
    output state_t     state_dbg
);

    state_t      state;
    state_t      next_state;
    logic [6:0]  byte_cnt;
    logic        eop_pend;

    logic        eopq;
    logic        pid_ok;
    logic        at_limit;

    logic        clr_cnt;
    logic        inc_cnt;
    logic        set_pend;
    logic        clr_pend;
    logic        latch_pid;
    logic        done_nxt;
    logic        clr_err;
    logic        set_err;

    assign eopq     = eop & shift_enable;
    assign at_limit = (byte_cnt == MAX_DATA_BYTES);

    usb_rx_pid_check u_pid_check (
        .pid_byte (rcv_data),
        .valid    (pid_ok)
    );

    // Next-state selection plus the one-cycle side-effect strobes of each transition.
    always_comb begin
        next_state = state;
        clr_cnt    = 1'b0;
        inc_cnt    = 1'b0;
        set_pend   = 1'b0;
        clr_pend   = 1'b0;
        latch_pid  = 1'b0;
        done_nxt   = 1'b0;
        clr_err    = 1'b0;
        case (state)
            IDLE: begin
                if (d_edge) begin
                    next_state = SYNC_WAIT;
                    clr_cnt    = 1'b1;
                end
            end
            SYNC_WAIT: begin
                if (byte_received)  next_state = SYNC_CHK;
                else if (eopq)      next_state = ERR_EOP;
            end
            SYNC_CHK: begin
                next_state = (rcv_data == SYNC_BYTE) ? PID_WAIT : ERR_WAIT;
            end
            PID_WAIT: begin
                if (byte_received)  next_state = PID_CHK;
                else if (eopq)      next_state = ERR_EOP;
            end
            PID_CHK: begin
                if (pid_ok) begin
                    next_state = DATA_WAIT;
                    latch_pid  = 1'b1;
                end else begin
                    next_state = ERR_WAIT;
                end
            end
            DATA_WAIT: begin
                if (byte_received) begin
                    next_state = DATA_STORE;
                    set_pend   = eopq;
                end else if (eopq) begin
                    next_state = EOP_HOLD;
                end
            end
            DATA_STORE: begin
                // A store past the payload limit is dropped and the packet errored.
                clr_pend = 1'b1;
                if (at_limit) begin
                    next_state = ERR_WAIT;
                end else begin
                    inc_cnt    = 1'b1;
                    next_state = eop_pend ? EOP_HOLD : DATA_WAIT;
                end
            end
            EOP_HOLD: begin
                if (d_edge) begin
                    next_state = IDLE;
                    done_nxt   = 1'b1;
                end
            end
            ERR_WAIT: begin
                if (eopq) next_state = ERR_EOP;
            end
            ERR_EOP: begin
                if (d_edge) next_state = ERR_IDLE;
            end
            ERR_IDLE: begin
                if (d_edge) begin
                    next_state = SYNC_WAIT;
                    clr_cnt    = 1'b1;
                    clr_err    = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign set_err = (next_state == ERR_WAIT) || (next_state == ERR_EOP);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Byte counter, pending-EOP flag, PID latch, error flag and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= 7'd0;
            eop_pend <= 1'b0;
            pid      <= 4'h0;
            r_error  <= 1'b0;
            pkt_done <= 1'b0;
        end else begin
            if (clr_cnt)                  byte_cnt <= 7'd0;
            else if (inc_cnt && !at_limit) byte_cnt <= byte_cnt + 7'd1;

            if (clr_cnt || clr_pend)      eop_pend <= 1'b0;
            else if (set_pend)            eop_pend <= 1'b1;

            if (latch_pid)                pid <= rcv_data[3:0];

            if (clr_err)                  r_error <= 1'b0;
            else if (set_err)             r_error <= 1'b1;

            pkt_done <= done_nxt;
        end
    end

    // Outputs decoded from registered state only.
    assign receiving = (state != IDLE) && (state != ERR_IDLE);
    assign w_enable  = (state == DATA_STORE) && !at_limit;
    assign state_dbg = state;

endmodule

// File: doc/usb_rx_ctrl.md
USB_RX_CTRL -- requirements
Module: usb_rx_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port d_edge, input, 1 bit: one-cycle pulse on a decoded D+/D- transition.
REQ-004 The block SHALL have port eop, input, 1 bit: SE0 present on the bus; acted on only when shift_enable=1.
REQ-005 The block SHALL have port shift_enable, input, 1 bit: bit-sample strobe from the receiver timer.
REQ-006 The block SHALL have port byte_received, input, 1 bit: one-cycle pulse when 8 bits are assembled.
REQ-007 The block SHALL have port rcv_data, input, 8 bits: last assembled byte, valid while byte_received=1 and on the following cycle.
REQ-008 The block SHALL have port receiving, output, 1 bit: packet in progress; feeds the timer count_enable.
REQ-009 The block SHALL have port w_enable, output, 1 bit: one-cycle write strobe of rcv_data into the RX FIFO.
REQ-010 The block SHALL have port r_error, output, 1 bit: sticky receive error.
REQ-011 The block SHALL have port pid, output, 4 bits: latched PID of the current or last packet.
REQ-012 The block SHALL have port pkt_done, output, 1 bit: one-cycle pulse on clean packet end.

Function
REQ-013 The block SHALL implement the states IDLE, SYNC_WAIT, SYNC_CHK, PID_WAIT, PID_CHK, DATA_WAIT, DATA_STORE, EOP_HOLD, ERR_WAIT, ERR_EOP and ERR_IDLE, with one transition evaluated per clk.
REQ-014 Let eopq = eop & shift_enable; from IDLE, d_edge SHALL cause a transition to SYNC_WAIT.
REQ-015 In SYNC_WAIT, byte_received SHALL cause a transition to SYNC_CHK, and eopq SHALL cause a transition to ERR_EOP.
REQ-016 In SYNC_CHK (one cycle), rcv_data==SYNC_BYTE SHALL cause a transition to PID_WAIT; otherwise the block SHALL go to ERR_WAIT.
REQ-017 In PID_WAIT, byte_received SHALL cause a transition to PID_CHK, and eopq SHALL cause a transition to ERR_EOP.
REQ-018 In PID_CHK (one cycle), pid SHALL latch rcv_data[3:0] and the block SHALL go to DATA_WAIT, or SHALL go to ERR_WAIT when the PID is invalid (REQ-032).
REQ-019 In DATA_WAIT, byte_received SHALL cause a transition to DATA_STORE, and eopq alone SHALL cause a transition to EOP_HOLD.
REQ-020 When byte_received and eopq occur in the same cycle, the block SHALL go to DATA_STORE and set eop_pend.
REQ-021 In DATA_STORE (one cycle), the block SHALL assert w_enable=1, increment byte_cnt, and then go to EOP_HOLD if eop_pend is set, else to DATA_WAIT.
REQ-022 When a store would make byte_cnt exceed MAX_DATA_BYTES, w_enable SHALL NOT be asserted and the block SHALL go to ERR_WAIT.
REQ-023 In EOP_HOLD, d_edge (return to J) SHALL cause a one-cycle pkt_done pulse and a transition to IDLE.
REQ-024 In ERR_WAIT, eopq SHALL cause a transition to ERR_EOP, and in ERR_EOP, d_edge SHALL cause a transition to ERR_IDLE.
REQ-025 In ERR_IDLE, d_edge SHALL clear r_error and cause a transition to SYNC_WAIT.
REQ-026 r_error SHALL be set on entry to ERR_WAIT or ERR_EOP and SHALL hold until cleared per REQ-025.
REQ-027 receiving SHALL be 1 in every state except IDLE and ERR_IDLE.
REQ-028 byte_cnt SHALL be a 7-bit counter, cleared on leaving IDLE or ERR_IDLE, and shall never wrap.
REQ-029 All outputs SHALL be registered or decoded from state only, with no combinational path from inputs to outputs.

Reset
REQ-030 While rst=1, the block SHALL hold state=IDLE with receiving=0, w_enable=0, r_error=0, pid=4'h0, pkt_done=0, byte_cnt=0 and eop_pend=0.
REQ-031 Assertion of rst mid-packet SHALL abort the packet immediately, with no w_enable or pkt_done generated after rst asserts.

Configuration
REQ-032 With macro USB_RX_PID_CHECK_EN defined, a PID SHALL be valid only when rcv_data[7:4] == ~rcv_data[3:0]; without it, every PID SHALL be accepted and rcv_data[7:4] ignored.

Structure
REQ-033 Package usb_rx_pkg SHALL hold the state enum, SYNC_BYTE=8'h80 and MAX_DATA_BYTES=7'd64.
REQ-034 PID validation SHALL be implemented as sub-module usb_rx_pid_check: combinational, input 8 bits, output 1-bit valid.

Verification
REQ-035 The bench SHALL drive d_edge, SYNC 8'h80, PID 8'hD2, data bytes 8'h11/8'h22, then eopq and d_edge, and SHALL check two w_enable pulses, pid=4'h2, one pkt_done pulse and r_error=0.
REQ-036 The bench SHALL drive a sync byte of 8'h81 and SHALL check ERR_WAIT entry and r_error=1 with no w_enable; after eopq and d_edge the block SHALL be in ERR_IDLE, and the next d_edge SHALL clear r_error.
REQ-037 With USB_RX_PID_CHECK_EN defined, PID 8'hD3 SHALL produce r_error=1; with the macro undefined, the same PID SHALL be accepted with pid=4'h3.
REQ-038 The bench SHALL drive byte_received and eopq in the same cycle in DATA_WAIT and SHALL check one w_enable, then EOP_HOLD, then pkt_done on d_edge.
REQ-039 The bench SHALL drive 65 data bytes and SHALL check exactly 64 w_enable pulses, then r_error=1.
REQ-040 The bench SHALL assert rst during DATA_WAIT and SHALL check that all outputs take their REQ-030 values asynchronously, before the next clk edge.
